// File: rtl/seven_seg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_pkg
// Description : Shared constants for the seven-segment scanner: hex font,
//               blank pattern and active-low pin polarities.
// Revision    : 1.0 - initial release
// ============================================================================
package seven_seg_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic       AN_ON   = 1'b0;
    localparam logic       AN_OFF  = 1'b1;
    localparam logic       DP_ON   = 1'b0;
    localparam logic       DP_OFF  = 1'b1;

    // Segment order {g,f,e,d,c,b,a}, active-low; entry 0 is the rightmost.
    localparam logic [15:0][6:0] HEX_FONT = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

endpackage
`default_nettype wire

// File: rtl/seven_seg_scanner_if.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_scanner_if
// Description : Producer-side and pin-side signal bundle of the scanner.
//               SEVEN_SEG_DIM_EN adds the brightness input.
// Revision    : 1.0 - initial release
// ============================================================================
interface seven_seg_scanner_if #(
    parameter int NUM_DIGITS = 8
);
    logic [4*NUM_DIGITS-1:0] value;
    logic                    load;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic                    blank_lz;
    logic                    enable;
`ifdef SEVEN_SEG_DIM_EN
    logic [3:0]              brightness;
`endif
    logic [6:0]              C;
    logic [NUM_DIGITS-1:0]   AN;
    logic                    DP;
    logic                    frame_done;

`ifdef SEVEN_SEG_DIM_EN
    modport master (output value, load, dp_in, blank_lz, enable, brightness,
                    input  C, AN, DP, frame_done);
    modport slave  (input  value, load, dp_in, blank_lz, enable, brightness,
                    output C, AN, DP, frame_done);
`else
    modport master (output value, load, dp_in, blank_lz, enable,
                    input  C, AN, DP, frame_done);
    modport slave  (input  value, load, dp_in, blank_lz, enable,
                    output C, AN, DP, frame_done);
`endif

endinterface
`default_nettype wire

// File: rtl/seven_seg_font.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_font
// Description : Combinational hex nibble to active-low segment lookup.
// Revision    : 1.0 - initial release
// ============================================================================
module seven_seg_font
    import seven_seg_pkg::*;
(
    input  wire logic [3:0] nibble_i,
    output logic      [6:0] seg_o
);

    always_comb begin
        seg_o = HEX_FONT[nibble_i];
    end

endmodule
`default_nettype wire

// File: rtl/seven_seg_scanner.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_scanner
// Description : Multiplexed N-digit hex display driver with double-buffered
//               loading, leading-zero blanking, anti-ghost guard interval and
//               frame-done strobe. Macro SEVEN_SEG_DIM_EN adds PWM dimming.
// Revision    : 1.0 - initial release
// ============================================================================
module seven_seg_scanner
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int PRESCALE_W = 14,
    parameter int GUARD      = 4
) (
    input  wire logic            clk,
    input  wire logic            rst,
    seven_seg_scanner_if.slave   bus
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int VAL_W = 4 * NUM_DIGITS;

    logic [PRESCALE_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [VAL_W-1:0]      act_val_q, act_val_d;
    logic [NUM_DIGITS-1:0] act_dp_q, act_dp_d;
    logic [VAL_W-1:0]      pend_val_q, pend_val_d;
    logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d;
    logic                  pend_valid_q, pend_valid_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [6:0]            c_q, c_d;
    logic                  dp_q, dp_d;
    logic                  fd_q, fd_d;

    logic                  w_tc;
    logic                  w_last;
    logic                  w_boundary;
    logic [3:0]            w_nib;
    logic [6:0]            w_seg;
    logic                  w_dp_lit;
    logic                  w_blank;
    logic                  w_duty;
    logic                  w_show;
    logic                  w_zrun;
    logic [NUM_DIGITS-1:0] w_lz_mask;

    assign w_tc       = &cnt_q;
    assign w_last     = (idx_q == IDX_W'(NUM_DIGITS - 1));
    assign w_boundary = bus.enable & w_tc & w_last;

    // Scan position: prescaler and digit index both freeze while disabled.
    always_comb begin
        cnt_d = cnt_q;
        idx_d = idx_q;
        if (bus.enable) begin
            cnt_d = cnt_q + PRESCALE_W'(1);
            if (w_tc) begin
                idx_d = w_last ? '0 : idx_q + IDX_W'(1);
            end
        end
    end

    // Double buffer: a load landing exactly on the boundary skips pending.
    always_comb begin
        act_val_d    = act_val_q;
        act_dp_d     = act_dp_q;
        pend_val_d   = pend_val_q;
        pend_dp_d    = pend_dp_q;
        pend_valid_d = pend_valid_q;
        if (w_boundary && pend_valid_q) begin
            act_val_d    = pend_val_q;
            act_dp_d     = pend_dp_q;
            pend_valid_d = 1'b0;
        end
        if (bus.load) begin
            if (w_boundary) begin
                act_val_d    = bus.value;
                act_dp_d     = bus.dp_in;
                pend_valid_d = 1'b0;
            end else begin
                pend_val_d   = bus.value;
                pend_dp_d    = bus.dp_in;
                pend_valid_d = 1'b1;
            end
        end
    end

    // Digit i is a leading zero when it and every digit above it are zero.
    always_comb begin
        w_zrun    = 1'b1;
        w_lz_mask = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            w_zrun       = w_zrun & (act_val_q[4*i +: 4] == 4'h0);
            w_lz_mask[i] = w_zrun & (i != 0);
        end
    end

    assign w_nib    = act_val_q[{idx_q, 2'b00} +: 4];
    assign w_dp_lit = act_dp_q[idx_q];
    assign w_blank  = bus.blank_lz & w_lz_mask[idx_q];

`ifdef SEVEN_SEG_DIM_EN
    assign w_duty = (cnt_q[3:0] < bus.brightness);
`else
    assign w_duty = 1'b1;
`endif

    assign w_show = bus.enable & (cnt_q >= PRESCALE_W'(GUARD)) & w_duty;

    seven_seg_font u_font (
        .nibble_i (w_nib),
        .seg_o    (w_seg)
    );

    always_comb begin
        an_d = {NUM_DIGITS{AN_OFF}};
        c_d  = SEG_OFF;
        dp_d = DP_OFF;
        fd_d = w_boundary;
        if (w_show) begin
            dp_d = w_dp_lit ? DP_ON : DP_OFF;
            if (!w_blank) begin
                an_d[idx_q] = AN_ON;
                c_d         = w_seg;
            end else if (w_dp_lit) begin
                // Blanked digit still lights its anode to carry the point.
                an_d[idx_q] = AN_ON;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            act_val_q    <= '0;
            act_dp_q     <= '0;
            pend_val_q   <= '0;
            pend_dp_q    <= '0;
            pend_valid_q <= 1'b0;
            an_q         <= {NUM_DIGITS{AN_OFF}};
            c_q          <= SEG_OFF;
            dp_q         <= DP_OFF;
            fd_q         <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            act_val_q    <= act_val_d;
            act_dp_q     <= act_dp_d;
            pend_val_q   <= pend_val_d;
            pend_dp_q    <= pend_dp_d;
            pend_valid_q <= pend_valid_d;
            an_q         <= an_d;
            c_q          <= c_d;
            dp_q         <= dp_d;
            fd_q         <= fd_d;
        end
    end

    assign bus.AN         = an_q;
    assign bus.C          = c_q;
    assign bus.DP         = dp_q;
    assign bus.frame_done = fd_q;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_seven_seg_scanner
// Description : Scoreboard bench for seven_seg_scanner (4 digits, 16-cycle
//               dwell, guard 2). Honours SEVEN_SEG_DIM_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seven_seg_scanner;

    localparam int N  = 4;
    localparam int PW = 4;
    localparam int G  = 2;
    localparam int DWELL = 1 << PW;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] c;
        logic       dp;
        logic       fd;
    } exp_t;

    logic clk;
    logic rst;
    seven_seg_scanner_if #(.NUM_DIGITS(N)) bus ();

    seven_seg_scanner #(
        .NUM_DIGITS (N),
        .PRESCALE_W (PW),
        .GUARD      (G)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_vec  = 0;
    int   n_miss = 0;
    exp_t sb_q[$];

    // Reference model state
    int         m_cnt, m_idx;
    logic [15:0] m_act, m_pend;
    logic [3:0]  m_actdp, m_penddp;
    bit          m_pv;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] font(input logic [3:0] n);
        case (n)
            4'h0: font = 7'b1000000;  4'h1: font = 7'b1111001;
            4'h2: font = 7'b0100100;  4'h3: font = 7'b0110000;
            4'h4: font = 7'b0011001;  4'h5: font = 7'b0010010;
            4'h6: font = 7'b0000010;  4'h7: font = 7'b1111000;
            4'h8: font = 7'b0000000;  4'h9: font = 7'b0010000;
            4'hA: font = 7'b0001000;  4'hB: font = 7'b0000011;
            4'hC: font = 7'b1000110;  4'hD: font = 7'b0100001;
            4'hE: font = 7'b0000110;  default: font = 7'b0001110;
        endcase
    endfunction

    // Predict the pins after the coming edge from the current inputs/state.
    task automatic model_step(output exp_t e);
        bit          lit, blanked, dpl, bnd;
        logic [3:0]  onehot;
        e = '{an: 4'hF, c: 7'h7F, dp: 1'b1, fd: 1'b0};
        if (rst) begin
            m_cnt = 0; m_idx = 0; m_act = '0; m_pend = '0;
            m_actdp = '0; m_penddp = '0; m_pv = 0;
            return;
        end
        lit = bus.enable && (m_cnt >= G);
`ifdef SEVEN_SEG_DIM_EN
        lit = lit && ((m_cnt % 16) < int'(bus.brightness));
`endif
        onehot  = ~(4'b0001 << m_idx);
        dpl     = m_actdp[m_idx];
        blanked = bus.blank_lz && (m_idx != 0) && ((m_act >> (4 * m_idx)) == 16'h0);
        if (lit) begin
            e.dp = ~dpl;
            if (!blanked) begin
                e.an = onehot;
                e.c  = font(m_act[4*m_idx +: 4]);
            end else if (dpl) begin
                e.an = onehot;
            end
        end
        bnd  = bus.enable && (m_cnt == DWELL - 1) && (m_idx == N - 1);
        e.fd = bnd;
        if (bnd && m_pv) begin
            m_act = m_pend; m_actdp = m_penddp; m_pv = 0;
        end
        if (bus.load) begin
            if (bnd) begin
                m_act = bus.value; m_actdp = bus.dp_in; m_pv = 0;
            end else begin
                m_pend = bus.value; m_penddp = bus.dp_in; m_pv = 1;
            end
        end
        if (bus.enable) begin
            if (m_cnt == DWELL - 1) m_idx = (m_idx + 1) % N;
            m_cnt = (m_cnt + 1) % DWELL;
        end
    endtask

    exp_t last_out;

    task automatic tick();
        exp_t e, x;
        model_step(e);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        x = sb_q.pop_front();
        last_out = '{an: bus.AN, c: bus.C, dp: bus.DP, fd: bus.frame_done};
        check("AN", 32'(bus.AN), 32'(x.an));
        check("C",  32'(bus.C),  32'(x.c));
        check("DP", 32'(bus.DP), 32'(x.dp));
        check("frame_done", 32'(bus.frame_done), 32'(x.fd));
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] dp);
        bus.value = v; bus.dp_in = dp; bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
    endtask

    // Advance until the DUT pulses frame_done; bounded.
    task automatic wait_fd(output int cycles);
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (!last_out.fd && cycles < 200);
        if (!last_out.fd) check("fd_timeout", 32'd0, 32'd1);
    endtask

    // Advance the model/DUT until the model is at a given scan position.
    task automatic goto_pos(input int idx, input int cnt);
        int guard_n = 0;
        while (!(m_idx == idx && m_cnt == cnt) && guard_n < 200) begin
            tick();
            guard_n++;
        end
        if (guard_n >= 200) check("pos_timeout", 32'd0, 32'd1);
    endtask

    int cyc;
    int fd_seen;

    initial begin
        rst = 1'b1;
        bus.value = '0; bus.load = 1'b0; bus.dp_in = '0;
        bus.blank_lz = 1'b0; bus.enable = 1'b1;
`ifdef SEVEN_SEG_DIM_EN
        bus.brightness = 4'd15;
`endif
        // 1: reset, then first lit cycle on digit 0
        run(3);
        check("rst_AN", 32'(bus.AN), 32'h0F);
        check("rst_C",  32'(bus.C),  32'h7F);
        rst = 1'b0;
        run(3);
`ifndef SEVEN_SEG_DIM_EN
        check("first_lit_AN", 32'(last_out.an), 32'b1110);
        check("first_lit_C",  32'(last_out.c),  32'b1000000);
`endif
        // 2: load 12AF and measure frame period
        do_load(16'h12AF, 4'b0100);
        wait_fd(cyc);
        wait_fd(cyc);
        check("fd_period", 32'(cyc), 32'(N * DWELL));
        run(70);
        // 3: last load before the boundary wins
        run(10);
        do_load(16'h1111, 4'b0000);
        run(20);
        do_load(16'h2222, 4'b0000);
        run(140);
        // Load coincident with boundary bypasses straight to active
        goto_pos(N - 1, DWELL - 1);
        do_load(16'h9876, 4'b1001);
        run(70);
        // 4: leading-zero blanking, with a point on a blanked digit
        bus.blank_lz = 1'b1;
        do_load(16'h0030, 4'b0000);
        run(140);
        do_load(16'h0000, 4'b0100);
        run(140);
        bus.blank_lz = 1'b0;
        // 5: disable mid-dwell of digit 2
        goto_pos(2, 8);
        bus.enable = 1'b0;
        fd_seen = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (last_out.fd) fd_seen++;
        end
        check("fd_while_disabled", 32'(fd_seen), 32'd0);
        check("dark_AN", 32'(last_out.an), 32'h0F);
        do_load(16'h4567, 4'b0010);
        bus.enable = 1'b1;
        run(100);
`ifdef SEVEN_SEG_DIM_EN
        // 6: dimming
        bus.brightness = 4'd4;
        run(140);
        bus.brightness = 4'd0;
        run(70);
        bus.brightness = 4'd15;
`endif
        // Reset mid-frame discards pending data
        goto_pos(1, 6);
        do_load(16'h5555, 4'b1111);
        rst = 1'b1;
        tick();
        check("midrst_AN", 32'(last_out.an), 32'h0F);
        rst = 1'b0;
        run(140);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
